// File: rtl/rsa_ctrl_pkg.sv
// Shared types for the rsa_unit enable/clear sequencer.
// Channel state encoding and the upper bound on channel count.
package rsa_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EN       = 3'd1,
        CLR_REL  = 3'd2,
        WAIT_EOC = 3'd3,
        DONE     = 3'd4,
        TOUT     = 3'd5
    } rsa_ch_state_t;

    localparam int NCH_MAX = 8;

endpackage

// File: rtl/rsa_ch_ctrl.sv
// One channel of the rsa_unit sequencer: start/stop edge detect, enable/clear
// FSM, WAIT_EOC timeout counter and sticky done/timeout status.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | unit disabled and held in clear; waits for a start edge
// EN       | unit enabled, still held in clear
// CLR_REL  | clear released; next cycle starts the conversion wait
// WAIT_EOC | waiting for end-of-conversion, timeout counter running
// DONE     | conversion finished (one cycle); restart or return to IDLE
// TOUT     | conversion timed out (one cycle); unit disabled and cleared
module rsa_ch_ctrl
    import rsa_ctrl_pkg::*;
#(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            ena,
    input  logic            start,
    input  logic            stop,
    input  logic            cont_mode,
    input  logic [TO_W-1:0] timeout_limit,
    input  logic            eoc_rsa,
    input  logic            irq_clr,
    output logic            en_rsa,
    output logic            clear_rsa,
    output logic            busy,
    output logic            done_sts,
    output logic            tout_sts
);

    rsa_ch_state_t   state, state_nxt;
    logic [TO_W-1:0] timer, timer_nxt;
    logic            start_d, stop_d;
    logic            start_rise, stop_rise;
    logic            done_nxt, tout_nxt;
    logic            sts_clr;

    assign start_rise = start & ~start_d;
    assign stop_rise  = stop & ~stop_d;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            IDLE: begin
                if (start_rise) state_nxt = EN;
            end
            EN: begin
                state_nxt = stop_rise ? IDLE : CLR_REL;
            end
            CLR_REL: begin
                if (stop_rise) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_EOC;
                    timer_nxt = '0;
                end
            end
            WAIT_EOC: begin
                // Comparison fires at limit-1, so the counter never wraps.
                if (stop_rise) begin
                    state_nxt = IDLE;
                end else if (eoc_rsa) begin
                    state_nxt = DONE;
                end else if ((timeout_limit != '0) &&
                             (timer == timeout_limit - TO_W'(1))) begin
                    state_nxt = TOUT;
                end else begin
                    timer_nxt = timer + TO_W'(1);
                end
            end
            DONE: begin
                if (stop_rise)      state_nxt = IDLE;
                else if (cont_mode) state_nxt = EN;
                else                state_nxt = IDLE;
            end
            TOUT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Set wins over either clear source in the same cycle.
    always_comb begin
        sts_clr  = irq_clr | ((state == IDLE) & (start_rise | stop_rise));
        done_nxt = done_sts;
        tout_nxt = tout_sts;
        if (state == DONE)  done_nxt = 1'b1;
        else if (sts_clr)   done_nxt = 1'b0;
        if (state == TOUT)  tout_nxt = 1'b1;
        else if (sts_clr)   tout_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state    <= IDLE;
            timer    <= '0;
            start_d  <= 1'b0;
            stop_d   <= 1'b0;
            done_sts <= 1'b0;
            tout_sts <= 1'b0;
        end else if (ena) begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            start_d  <= start;
            stop_d   <= stop;
            done_sts <= done_nxt;
            tout_sts <= tout_nxt;
        end
    end

    always_comb begin
        en_rsa    = 1'b0;
        clear_rsa = 1'b0;
        case (state)
            EN: begin
                en_rsa = 1'b1;
            end
            CLR_REL, WAIT_EOC, DONE: begin
                en_rsa    = 1'b1;
                clear_rsa = 1'b1;
            end
            default: begin
                en_rsa    = 1'b0;
                clear_rsa = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/rsa_multi_en_logic.sv
// Multi-channel enable/clear sequencer for an array of rsa_unit instances,
// with a masked, aggregated status interrupt.
module rsa_multi_en_logic
    import rsa_ctrl_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            ena,
    input  logic [NCH-1:0]  start,
    input  logic [NCH-1:0]  stop,
    input  logic [NCH-1:0]  cont_mode,
    input  logic [TO_W-1:0] timeout_limit,
    input  logic [NCH-1:0]  eoc_rsa,
    input  logic [NCH-1:0]  irq_mask,
    input  logic [NCH-1:0]  irq_clr,
    output logic [NCH-1:0]  en_rsa,
    output logic [NCH-1:0]  clear_rsa,
    output logic [NCH-1:0]  busy,
    output logic [NCH-1:0]  done_sts,
    output logic [NCH-1:0]  tout_sts,
    output logic            irq
);

    if ((NCH < 1) || (NCH > NCH_MAX)) begin : g_nch_check
        $error("rsa_multi_en_logic: NCH out of range");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        rsa_ch_ctrl #(
            .TO_W (TO_W)
        ) u_ch (
            .clk           (clk),
            .rstb          (rstb),
            .ena           (ena),
            .start         (start[i]),
            .stop          (stop[i]),
            .cont_mode     (cont_mode[i]),
            .timeout_limit (timeout_limit),
            .eoc_rsa       (eoc_rsa[i]),
            .irq_clr       (irq_clr[i]),
            .en_rsa        (en_rsa[i]),
            .clear_rsa     (clear_rsa[i]),
            .busy          (busy[i]),
            .done_sts      (done_sts[i]),
            .tout_sts      (tout_sts[i])
        );
    end

    // Built only from registered status, so the mask path is the only
    // combinational input and irq cannot glitch on state changes.
    assign irq = |((done_sts | tout_sts) & irq_mask);

endmodule

// File: tb/tb_rsa_multi_en_logic.sv
// Directed bench for rsa_multi_en_logic; completion events are checked
// through a scoreboard fed by the stimulus and drained by a status monitor.
module tb_rsa_multi_en_logic;

    localparam int NCH  = 2;
    localparam int TO_W = 16;

    logic            clk = 1'b0;
    logic            rstb, ena;
    logic [NCH-1:0]  start, stop, cont_mode, eoc_rsa, irq_mask, irq_clr;
    logic [TO_W-1:0] timeout_limit;
    logic [NCH-1:0]  en_rsa, clear_rsa, busy, done_sts, tout_sts;
    logic            irq;

    typedef struct {
        int ch;
        bit is_tout;
    } exp_t;

    exp_t           sb[$];
    int             total = 0;
    int             bad   = 0;
    logic [NCH-1:0] prev_done = '0;
    logic [NCH-1:0] prev_tout = '0;
    int             busy_cnt;

    rsa_multi_en_logic #(.NCH(NCH), .TO_W(TO_W)) dut (
        .clk           (clk),
        .rstb          (rstb),
        .ena           (ena),
        .start         (start),
        .stop          (stop),
        .cont_mode     (cont_mode),
        .timeout_limit (timeout_limit),
        .eoc_rsa       (eoc_rsa),
        .irq_mask      (irq_mask),
        .irq_clr       (irq_clr),
        .en_rsa        (en_rsa),
        .clear_rsa     (clear_rsa),
        .busy          (busy),
        .done_sts      (done_sts),
        .tout_sts      (tout_sts),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input bit is_tout);
        exp_t e;
        e.ch = ch;
        e.is_tout = is_tout;
        sb.push_back(e);
    endtask

    // Every rising status bit must match the oldest expected completion.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 2; k++) begin
                logic rose;
                exp_t e;
                rose = (k == 0) ? (done_sts[c] & ~prev_done[c]) : (tout_sts[c] & ~prev_tout[c]);
                if (rose) begin
                    total++;
                    assert (sb.size() != 0) else begin
                        bad++;
                        $error("FAIL sb_unexpected observed=ch%0d/kind%0d expected=none", c, k);
                    end
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        total++;
                        assert ((e.ch == c) && (int'(e.is_tout) == k)) else begin
                            bad++;
                            $error("FAIL sb_event observed=ch%0d/kind%0d expected=ch%0d/kind%0d",
                                   c, k, e.ch, e.is_tout);
                        end
                    end
                end
            end
        end
        prev_done = done_sts;
        prev_tout = tout_sts;
    end

    initial begin
        rstb = 1'b0; ena = 1'b1; start = '0; stop = '0; cont_mode = '0;
        eoc_rsa = '0; irq_mask = '0; irq_clr = '0; timeout_limit = '0;
        tick(2);
        chk("rst_en", en_rsa, 0);
        chk("rst_clr", clear_rsa, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sts", {done_sts, tout_sts}, 0);
        chk("rst_irq", irq, 0);
        rstb = 1'b1;
        tick();

        // Basic run on channel 0, channel 1 idle throughout
        irq_mask = 2'b01;
        start = 2'b01; tick();
        chk("b_en_state_en", en_rsa, 2'b01);
        chk("b_en_state_clr", clear_rsa, 2'b00);
        chk("b_en_busy", busy, 2'b01);
        start = 2'b00; tick();
        chk("b_clrrel_clr", clear_rsa, 2'b01);
        tick();
        tick(10);
        chk("b_wait_busy", busy, 2'b01);
        chk("b_wait_done", done_sts, 2'b00);
        eoc_rsa = 2'b01; tick();
        eoc_rsa = 2'b00;
        chk("b_done_state", {en_rsa, clear_rsa, done_sts}, 6'b01_01_00);
        push(0, 1'b0);
        tick();
        chk("b_done_sts", done_sts, 2'b01);
        chk("b_idle_busy", busy, 2'b00);
        chk("b_irq", irq, 1'b1);
        irq_clr = 2'b01; tick();
        irq_clr = 2'b00;
        chk("b_clr_sts", done_sts, 2'b00);
        chk("b_clr_irq", irq, 1'b0);

        // Timeout with limit 5
        timeout_limit = 16'd5;
        start = 2'b01; tick();
        start = 2'b00; tick(2);
        tick(4);
        chk("t_wait4", {en_rsa, clear_rsa}, 4'b01_01);
        tick();
        chk("t_tout_outs", {en_rsa, clear_rsa, busy}, 6'b00_00_01);
        chk("t_tout_sts_early", tout_sts, 2'b00);
        push(0, 1'b1);
        tick();
        chk("t_sts", {tout_sts, done_sts}, 4'b01_00);
        chk("t_busy", busy, 2'b00);

        // Aborts in EN, CLR_REL, WAIT_EOC, then stop together with eoc
        timeout_limit = '0;
        start = 2'b01; tick();
        start = 2'b00; stop = 2'b01; tick();
        stop = 2'b00;
        chk("a_en_busy", busy, 2'b00);
        chk("a_start_clears_tout", tout_sts, 2'b00);
        start = 2'b01; tick();
        start = 2'b00; tick();
        stop = 2'b01; tick();
        stop = 2'b00;
        chk("a_clrrel_busy", busy, 2'b00);
        start = 2'b01; tick();
        start = 2'b00; tick(4);
        stop = 2'b01; tick();
        stop = 2'b00;
        chk("a_wait_busy", busy, 2'b00);
        start = 2'b01; tick();
        start = 2'b00; tick(3);
        stop = 2'b01; eoc_rsa = 2'b01; tick();
        stop = 2'b00; eoc_rsa = 2'b00;
        chk("a_stop_eoc_busy", busy, 2'b00);
        tick();
        chk("a_stop_eoc_sts", {done_sts, tout_sts}, 4'b00_00);

        // Continuous mode: three runs, leave after the third DONE
        cont_mode = 2'b01;
        start = 2'b01; tick();
        start = 2'b00;
        for (int r = 0; r < 3; r++) begin
            tick(2);
            if (r == 2) cont_mode = 2'b00;
            eoc_rsa = 2'b01; tick();
            eoc_rsa = 2'b00;
            chk($sformatf("c_done_r%0d", r), {en_rsa, clear_rsa}, 4'b01_01);
            if (r == 0) push(0, 1'b0);
            tick();
            if (r < 2) chk($sformatf("c_restart_r%0d", r), {en_rsa, clear_rsa, busy}, 6'b01_00_01);
            else       chk("c_stop_idle", busy, 2'b00);
            chk($sformatf("c_sticky_r%0d", r), done_sts, 2'b01);
        end

        // Masking, set-beats-clear, held start
        irq_mask = 2'b00; #1;
        chk("m_masked_irq", irq, 1'b0);
        irq_mask = 2'b01; #1;
        chk("m_unmasked_irq", irq, 1'b1);
        irq_clr = 2'b01; tick();
        irq_clr = 2'b00;
        chk("m_cleared", done_sts, 2'b00);
        start = 2'b01; tick();
        start = 2'b00; tick(2);
        eoc_rsa = 2'b01; tick();
        eoc_rsa = 2'b00; irq_clr = 2'b01;
        push(0, 1'b0);
        tick();
        irq_clr = 2'b00;
        chk("m_set_beats_clr", done_sts, 2'b01);
        start = 2'b01; tick(3);
        eoc_rsa = 2'b01; tick();
        eoc_rsa = 2'b00;
        push(0, 1'b0);
        tick();
        busy_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy[0]) busy_cnt++;
        end
        chk("m_held_start_one_run", busy_cnt, 0);
        start = 2'b00; tick();
        chk("m_held_start_done", done_sts, 2'b01);

        // Both channels at once, ena freeze delays the timeout by 8 cycles
        timeout_limit = 16'd5;
        start = 2'b11; tick();
        start = 2'b00;
        chk("e_both_en", en_rsa, 2'b11);
        tick(2);
        tick(2);
        ena = 1'b0; tick(8);
        chk("e_frozen", {en_rsa, clear_rsa, busy}, 6'b11_11_11);
        ena = 1'b1;
        tick(2);
        chk("e_still_wait", clear_rsa, 2'b11);
        tick();
        chk("e_tout", {en_rsa, clear_rsa, busy}, 6'b00_00_11);
        push(0, 1'b1);
        push(1, 1'b1);
        tick();
        chk("e_tout_sts", tout_sts, 2'b11);
        chk("e_irq", irq, 1'b1);

        // Reset mid-WAIT_EOC, overriding ena=0
        irq_clr = 2'b11; tick();
        irq_clr = 2'b00;
        start = 2'b01; tick();
        start = 2'b00; tick(3);
        chk("r_pre_busy", busy, 2'b01);
        rstb = 1'b0; ena = 1'b0; tick();
        chk("r_outs", {en_rsa, clear_rsa, busy, irq}, 7'b0);
        rstb = 1'b1; ena = 1'b1; tick(2);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsa_multi_en_logic.md
Name: rsa_multi_en_logic

Overview:
Multi-channel, parametrised enable/clear sequencer for NCH independent rsa_unit instances. Each channel turns start/stop rising edges into en_rsa/clear_rsa sequencing and waits for end-of-conversion. It adds a programmable timeout, a continuous (auto-restart) mode, sticky done/timeout status with write-1-to-clear, and one masked, aggregated irq. It sits between the peripheral register interface and the rsa_unit array.

Parameters:
NCH, 2, number of channels (1..8)
TO_W, 16, width of the timeout counter and of timeout_limit

Ports:
clk  in  1  clock
rstb  in  1  reset: synchronous, active-low
ena  in  1  global enable; when low, all flops hold their value
start  in  NCH  per-channel start request; acts on its rising edge
stop  in  NCH  per-channel abort request; acts on its rising edge
cont_mode  in  NCH  1 = re-run automatically after done
timeout_limit  in  TO_W  WAIT_EOC cycle limit, shared by all channels; 0 = timeout disabled
eoc_rsa  in  NCH  end-of-conversion from each rsa_unit
irq_mask  in  NCH  1 = channel status may drive irq
irq_clr  in  NCH  write-1-to-clear pulse for that channel's status bits
en_rsa  out  NCH  enable to each rsa_unit
clear_rsa  out  NCH  active-low clear to each rsa_unit (0 = held in clear)
busy  out  NCH  channel state is not IDLE
done_sts  out  NCH  sticky: conversion completed
tout_sts  out  NCH  sticky: timeout occurred
irq  out  1  OR over channels of ((done_sts | tout_sts) & irq_mask)

Behaviour:
- Reset (rstb=0 at a clk edge): every state becomes IDLE; edge registers, timers, done_sts and tout_sts go to 0. Resulting outputs: en_rsa=0, clear_rsa=0, busy=0, irq=0. Reset overrides ena and aborts any channel mid-operation.
- ena=0: nothing updates (state, edge registers, timers, status). Outputs hold because they decode from flops.
- Edge detect per channel, updated only when ena=1: start_d <= start, stop_d <= stop.
  - start_rise = start & ~start_d
  - stop_rise = stop & ~stop_d
  - A level held high gives exactly one event.
- Per-channel FSM. Outputs are Moore decodes of state; each row gives en_rsa/clear_rsa:
  - IDLE, 0/0: start_rise -> EN.
  - EN, 1/0: stop_rise -> IDLE; otherwise -> CLR_REL.
  - CLR_REL, 1/1: stop_rise -> IDLE; otherwise -> WAIT_EOC, and timer <= 0.
  - WAIT_EOC, 1/1: priority order is
    1. stop_rise -> IDLE
    2. eoc_rsa -> DONE
    3. timeout_limit != 0 and timer == timeout_limit-1 -> TOUT
    4. otherwise timer <= timer+1
  - DONE, 1/1, lasts one cycle: stop_rise -> IDLE; else cont_mode=1 -> EN; else -> IDLE.
  - TOUT, 0/0, lasts one cycle: -> IDLE.
  - Any illegal encoding -> IDLE.
- start_rise is ignored in every state except IDLE. stop_rise in IDLE has no state effect.
- Latency: start rising edge sampled at edge k gives EN after edge k, CLR_REL after k+1, WAIT_EOC after k+2. eoc_rsa sampled in WAIT_EOC gives DONE one edge later, and done_sts=1 one edge after that.
- Timeout: with limit L, TOUT is entered after exactly L cycles in WAIT_EOC if no eoc/stop arrives. The timer is TO_W bits and never wraps, since the comparison fires first.
- Status bits, per channel, priority high to low:
  1. Set: done_sts <= 1 on the edge leaving DONE; tout_sts <= 1 on the edge leaving TOUT.
  2. Clear: irq_clr[i]=1 clears both bits.
  3. Clear: start_rise or stop_rise accepted in IDLE clears both bits.
  - Set beats clear in the same cycle.
- irq is combinational from registered status and mask, so it is glitch-free. Changing irq_mask takes effect the same cycle.
- Channels are fully independent. Simultaneous events on different channels are all processed in the same cycle.

Decomposition:
- Package rsa_ctrl_pkg holds:
  - typedef enum logic [2:0] rsa_ch_state_t {IDLE, EN, CLR_REL, WAIT_EOC, DONE, TOUT}
  - localparam NCH_MAX = 8
- Sub-module rsa_ch_ctrl (parameter TO_W) contains one channel's edge detect, FSM, timer and status bits.
- The top generates NCH instances and performs the irq reduction.

Test Plan:
- Basic run, NCH=2, limit=0: pulse start[0] -> en_rsa[0]=1 at +1, clear_rsa[0]=1 at +2; eoc_rsa[0] after 10 cycles -> done_sts[0]=1 two edges later; mask=01 -> irq=1; irq_clr[0] -> irq=0; channel 1 untouched throughout.
- Timeout: limit=5, no eoc -> TOUT after exactly 5 WAIT_EOC cycles; en_rsa=0 and clear_rsa=0 in TOUT; tout_sts=1, done_sts=0; busy returns to 0.
- Abort: stop rising edge in EN, CLR_REL and WAIT_EOC, one run each -> IDLE next edge, no status set. Stop and eoc in the same cycle -> IDLE, done_sts stays 0.
- Continuous mode: cont_mode=1 with eoc every run -> DONE->EN->CLR_REL loops for 3 runs with done_sts sticky; clear cont_mode -> stops in IDLE after the next DONE.
- Masking and priority: irq_mask=0 with done set -> irq=0, then set mask -> irq=1 same cycle. irq_clr asserted on the same edge status sets -> status=1. start held high for 20 cycles -> exactly one run.
- Control: ena=0 in WAIT_EOC for 8 cycles -> timer and state frozen, TOUT delayed by 8 cycles. rstb=0 mid-WAIT_EOC -> all outputs 0 at the next edge.
